// File: rtl/game_flow_controller.sv
// Frogger game sequencer: state machine, lives/level counters and frame-paced pause timers.
// Optional hit flash of the frog sprite is enabled by defining GAME_FLOW_HIT_FLASH_EN.
module game_flow_controller #(
  parameter int c_LIVES_INI      = 3,
  parameter int c_START_FRAMES   = 30,
  parameter int c_HIT_FRAMES     = 60,
  parameter int c_LEVELUP_FRAMES = 90,
  parameter int c_MAX_LEVEL      = 7
) (
  input  logic       i_Clk,
  input  logic       i_Rst_L,
  input  logic       i_Frame_Tick,
  input  logic       i_Start,
  input  logic       i_Has_Collided,
  input  logic       i_Level_Up,
  output logic       o_Game_Active,
  output logic       o_Obstacles_Run,
  output logic       o_Frog_Reset,
  output logic       o_Blank_Frog,
  output logic [1:0] o_Lives,
  output logic [2:0] o_Level,
  output logic       o_Game_Over,
  output logic [2:0] o_State
);

  typedef enum logic [2:0] {
    ST_IDLE        = 3'd0,
    ST_COUNTDOWN   = 3'd1,
    ST_RUNNING     = 3'd2,
    ST_HIT         = 3'd3,
    ST_LEVEL_PAUSE = 3'd4,
    ST_GAME_OVER   = 3'd5
  } state_e;

  localparam logic [7:0] START_LAST   = 8'(c_START_FRAMES - 1);
  localparam logic [7:0] HIT_LAST     = 8'(c_HIT_FRAMES - 1);
  localparam logic [7:0] LEVELUP_LAST = 8'(c_LEVELUP_FRAMES - 1);
  localparam logic [1:0] LIVES_INI    = 2'(c_LIVES_INI);
  localparam logic [2:0] LEVEL_MAX    = 3'(c_MAX_LEVEL);

  state_e     state_q, state_d;
  logic       start_prev_q;
  logic [7:0] frame_cnt_q, frame_cnt_d;
  logic [1:0] lives_q, lives_d;
  logic [2:0] level_q, level_d;
  logic       frog_reset_q, frog_reset_d;
  logic       game_active_q, game_active_d;
  logic       obstacles_run_q, obstacles_run_d;
  logic       blank_frog_q, blank_frog_d;
  logic       game_over_q, game_over_d;

  logic       start_edge;
  logic       timer_done;
  logic [7:0] timer_last;

  assign start_edge = i_Start & ~start_prev_q;

  always_comb begin
    timer_last = 8'hFF;
    case (state_q)
      ST_COUNTDOWN:   timer_last = START_LAST;
      ST_HIT:         timer_last = HIT_LAST;
      ST_LEVEL_PAUSE: timer_last = LEVELUP_LAST;
      default:        timer_last = 8'hFF;
    endcase
  end

  // The exiting tick is the PARAM-th one: the count already holds PARAM-1 ticks.
  assign timer_done = i_Frame_Tick && (frame_cnt_q == timer_last);

  always_comb begin
    // NOTE: every signal gets a default before the case so no path can infer a latch.
    state_d      = state_q;
    lives_d      = lives_q;
    level_d      = level_q;
    frog_reset_d = 1'b0;

    case (state_q)
      ST_IDLE, ST_GAME_OVER: begin
        if (start_edge) begin
          lives_d      = LIVES_INI;
          level_d      = 3'd0;
          frog_reset_d = 1'b1;
          state_d      = ST_COUNTDOWN;
        end
      end
      ST_COUNTDOWN: begin
        if (timer_done) state_d = ST_RUNNING;
      end
      ST_RUNNING: begin
        if (i_Has_Collided) begin
          if (lives_q > 2'd1) begin
            lives_d = lives_q - 2'd1;
            state_d = ST_HIT;
          end else begin
            lives_d = 2'd0;
            state_d = ST_GAME_OVER;
          end
        end else if (i_Level_Up) begin
          level_d = (level_q >= LEVEL_MAX) ? LEVEL_MAX : level_q + 3'd1;
          state_d = ST_LEVEL_PAUSE;
        end
      end
      ST_HIT, ST_LEVEL_PAUSE: begin
        if (timer_done) begin
          frog_reset_d = 1'b1;
          state_d      = ST_RUNNING;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    frame_cnt_d = (state_d != state_q) ? 8'd0 : frame_cnt_q + {7'd0, i_Frame_Tick};

    // Outputs are decoded from the next state so the registered copies line up with state_q.
    game_active_d   = (state_d == ST_RUNNING);
    obstacles_run_d = (state_d == ST_COUNTDOWN) || (state_d == ST_RUNNING) || (state_d == ST_HIT);
    game_over_d     = (state_d == ST_GAME_OVER);
`ifdef GAME_FLOW_HIT_FLASH_EN
    blank_frog_d    = (state_d == ST_HIT) && frame_cnt_d[3];
`else
    blank_frog_d    = 1'b0;
`endif
  end

  always_ff @(posedge i_Clk or negedge i_Rst_L) begin
    if (!i_Rst_L) begin
      state_q         <= ST_IDLE;
      start_prev_q    <= 1'b1;  // a switch held through reset must not look like a fresh press
      frame_cnt_q     <= 8'd0;
      lives_q         <= LIVES_INI;
      level_q         <= 3'd0;
      frog_reset_q    <= 1'b0;
      game_active_q   <= 1'b0;
      obstacles_run_q <= 1'b0;
      blank_frog_q    <= 1'b0;
      game_over_q     <= 1'b0;
    end else begin
      // NOTE: non-blocking updates so every register samples pre-edge values together.
      state_q         <= state_d;
      start_prev_q    <= i_Start;
      frame_cnt_q     <= frame_cnt_d;
      lives_q         <= lives_d;
      level_q         <= level_d;
      frog_reset_q    <= frog_reset_d;
      game_active_q   <= game_active_d;
      obstacles_run_q <= obstacles_run_d;
      blank_frog_q    <= blank_frog_d;
      game_over_q     <= game_over_d;
    end
  end

  assign o_State         = state_q;
  assign o_Lives         = lives_q;
  assign o_Level         = level_q;
  assign o_Frog_Reset    = frog_reset_q;
  assign o_Game_Active   = game_active_q;
  assign o_Obstacles_Run = obstacles_run_q;
  assign o_Blank_Frog    = blank_frog_q;
  assign o_Game_Over     = game_over_q;

endmodule

// File: tb/tb_game_flow_controller.sv
// Self-checking bench for game_flow_controller: directed scenarios plus randomized traffic
// compared against a rule-level game model (remaining-ticks countdown, plain integers).
module tb_game_flow_controller;

  localparam int LIVES_INI = 3;
  localparam int START_FR  = 30;
  localparam int HIT_FR    = 60;
  localparam int LVL_FR    = 90;
  localparam int MAX_LVL   = 7;

  localparam int S_IDLE = 0, S_CD = 1, S_RUN = 2, S_HIT = 3, S_LP = 4, S_GO = 5;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       tick = 1'b0, start = 1'b0, coll = 1'b0, lvl = 1'b0;
  logic       o_Game_Active, o_Obstacles_Run, o_Frog_Reset, o_Blank_Frog, o_Game_Over;
  logic [1:0] o_Lives;
  logic [2:0] o_Level, o_State;
  logic [12:0] dut_vec;

  int vectors = 0;
  int miscompares = 0;

  // Behavioural model of the game rules
  int m_state, m_lives, m_level, m_left, m_hit_ticks;
  bit m_prev, m_frog_reset;

  game_flow_controller dut (
    .i_Clk(clk), .i_Rst_L(rst_n), .i_Frame_Tick(tick), .i_Start(start),
    .i_Has_Collided(coll), .i_Level_Up(lvl),
    .o_Game_Active(o_Game_Active), .o_Obstacles_Run(o_Obstacles_Run),
    .o_Frog_Reset(o_Frog_Reset), .o_Blank_Frog(o_Blank_Frog),
    .o_Lives(o_Lives), .o_Level(o_Level), .o_Game_Over(o_Game_Over), .o_State(o_State)
  );

  assign dut_vec = {o_State, o_Lives, o_Level, o_Game_Active, o_Obstacles_Run,
                    o_Frog_Reset, o_Blank_Frog, o_Game_Over};

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation still running at %0t, required finish earlier", $time);
    $fatal(1);
  end

  function automatic int duration(input int s);
    case (s)
      S_CD:    return START_FR;
      S_HIT:   return HIT_FR;
      S_LP:    return LVL_FR;
      default: return 0;
    endcase
  endfunction

  function automatic void model_reset();
    m_state = S_IDLE; m_lives = LIVES_INI; m_level = 0;
    m_left = 0; m_hit_ticks = 0; m_prev = 1'b1; m_frog_reset = 1'b0;
  endfunction

  function automatic void model_step(input bit t, input bit s, input bit c, input bit l);
    int  nxt;
    bit  press;
    press = s && !m_prev;
    m_prev = s;
    m_frog_reset = 1'b0;
    nxt = m_state;
    case (m_state)
      S_IDLE, S_GO: if (press) begin
        m_lives = LIVES_INI; m_level = 0; m_frog_reset = 1'b1; nxt = S_CD;
      end
      S_CD: if (t) begin
        m_left--;
        if (m_left == 0) nxt = S_RUN;
      end
      S_RUN: begin
        if (c) begin
          if (m_lives > 1) begin m_lives--; nxt = S_HIT; end
          else begin m_lives = 0; nxt = S_GO; end
        end else if (l) begin
          m_level = (m_level + 1 > MAX_LVL) ? MAX_LVL : m_level + 1;
          nxt = S_LP;
        end
      end
      S_HIT, S_LP: if (t) begin
        m_left--;
        if (m_left == 0) begin m_frog_reset = 1'b1; nxt = S_RUN; end
      end
      default: nxt = S_IDLE;
    endcase
    if (nxt != m_state) begin
      m_left = duration(nxt);
      m_hit_ticks = 0;
    end else if (t) begin
      m_hit_ticks++;
    end
    m_state = nxt;
  endfunction

  function automatic logic [12:0] model_vec();
    logic blank;
    blank = 1'b0;
`ifdef GAME_FLOW_HIT_FLASH_EN
    blank = (m_state == S_HIT) && (((m_hit_ticks / 8) % 2) == 1);
`endif
    return {3'(m_state), 2'(m_lives), 3'(m_level), (m_state == S_RUN),
            (m_state == S_CD || m_state == S_RUN || m_state == S_HIT),
            m_frog_reset, blank, (m_state == S_GO)};
  endfunction

  // Drive one clock of inputs; the model advances on the same edge, outputs are read 1 ns later.
  task automatic step(input bit t, input bit s, input bit c, input bit l);
    tick = t; start = s; coll = c; lvl = l;
    @(posedge clk);
    model_step(t, s, c, l);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    tick = 0; start = 0; coll = 0; lvl = 0;
    @(posedge clk); #1;
    model_reset();
    rst_n = 1'b1;
  endtask

  task automatic start_game();
    step(0, 0, 0, 0);
    step(0, 1, 0, 0);
    step(0, 0, 0, 0);
    repeat (START_FR) step(1, 0, 0, 0);
  endtask

  task automatic test_reset();
    rst_n = 1'b0; start = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    model_reset();
    vectors++;
    if (dut_vec !== {3'd0, 2'd3, 3'd0, 5'b0}) begin
      miscompares++; $display("FAIL reset_values: got %b expected %b", dut_vec, {3'd0, 2'd3, 3'd0, 5'b0});
    end
    rst_n = 1'b1;
    for (int i = 0; i < 5; i++) begin step(1, 1, 0, 0); step(0, 1, 0, 0); end
    vectors++;
    if (o_State !== 3'd0 || o_Lives !== 2'd3) begin
      miscompares++; $display("FAIL held_start_idle: got state %0d lives %0d expected 0 3", o_State, o_Lives);
    end
    step(0, 0, 0, 0);
    step(0, 1, 0, 0);
    vectors++;
    if (o_Frog_Reset !== 1'b1 || o_State !== 3'd1) begin
      miscompares++; $display("FAIL start_press: got frog_reset %0b state %0d expected 1 1", o_Frog_Reset, o_State);
    end
    step(0, 1, 0, 0);
    vectors++;
    if (o_Frog_Reset !== 1'b0 || o_Obstacles_Run !== 1'b1) begin
      miscompares++; $display("FAIL start_pulse_once: got frog_reset %0b obst %0b expected 0 1", o_Frog_Reset, o_Obstacles_Run);
    end
    for (int i = 1; i <= START_FR; i++) begin
      step(1, 1, (i % 3) == 0, 0);
      if (i == START_FR - 1) begin
        vectors++;
        if (o_State !== 3'd1) begin
          miscompares++; $display("FAIL countdown_tick29: got state %0d expected 1", o_State);
        end
      end
    end
    vectors++;
    if (o_State !== 3'd2 || o_Game_Active !== 1'b1 || o_Lives !== 2'd3) begin
      miscompares++; $display("FAIL countdown_done: got state %0d active %0b lives %0d expected 2 1 3", o_State, o_Game_Active, o_Lives);
    end
  endtask

  task automatic test_collision();
    step(0, 0, 1, 0);
    vectors++;
    if (o_State !== 3'd3 || o_Lives !== 2'd2 || o_Game_Active !== 1'b0 || o_Obstacles_Run !== 1'b1) begin
      miscompares++; $display("FAIL hit_entry: got state %0d lives %0d active %0b obst %0b expected 3 2 0 1",
                              o_State, o_Lives, o_Game_Active, o_Obstacles_Run);
    end
    for (int i = 1; i <= HIT_FR; i++) begin
      logic exp_blank;
      bit   c, l;
      c = (i < HIT_FR) ? 1'($urandom_range(0, 1)) : 1'b0;
      l = (i < HIT_FR) ? 1'($urandom_range(0, 1)) : 1'b0;
      step(1, 0, c, l);
      if (i < HIT_FR) begin
`ifdef GAME_FLOW_HIT_FLASH_EN
        exp_blank = 1'(((i / 8) % 2) == 1);
`else
        exp_blank = 1'b0;
`endif
        vectors++;
        if (o_State !== 3'd3 || o_Lives !== 2'd2 || o_Frog_Reset !== 1'b0 || o_Blank_Frog !== exp_blank) begin
          miscompares++; $display("FAIL hit_hold tick %0d: got state %0d lives %0d fr %0b blank %0b expected 3 2 0 %0b",
                                  i, o_State, o_Lives, o_Frog_Reset, o_Blank_Frog, exp_blank);
        end
      end
    end
    vectors++;
    if (o_Frog_Reset !== 1'b1 || o_State !== 3'd2 || o_Blank_Frog !== 1'b0) begin
      miscompares++; $display("FAIL hit_exit: got fr %0b state %0d blank %0b expected 1 2 0", o_Frog_Reset, o_State, o_Blank_Frog);
    end
    step(0, 0, 0, 0);
    vectors++;
    if (o_Frog_Reset !== 1'b0) begin
      miscompares++; $display("FAIL hit_exit_pulse: got fr %0b expected 0", o_Frog_Reset);
    end
  endtask

  task automatic test_reset_mid_hit();
    step(0, 0, 1, 0);
    repeat (20) step(1, 0, 0, 0);
    #2 rst_n = 1'b0;
    #1;
    vectors++;
    if (dut_vec !== {3'd0, 2'd3, 3'd0, 5'b0}) begin
      miscompares++; $display("FAIL async_reset_mid_hit: got %b expected %b", dut_vec, {3'd0, 2'd3, 3'd0, 5'b0});
    end
    model_reset();
    tick = 0; start = 0; coll = 0; lvl = 0;
    @(posedge clk); #1;
    rst_n = 1'b1;
  endtask

  task automatic test_game_over();
    start_game();
    for (int k = 1; k <= 3; k++) begin
      step(0, 0, 1, 0);
      if (k < 3) begin
        vectors++;
        if (o_State !== 3'd3 || o_Lives !== 2'(3 - k)) begin
          miscompares++; $display("FAIL collision %0d: got state %0d lives %0d expected 3 %0d", k, o_State, o_Lives, 3 - k);
        end
        repeat (HIT_FR) step(1, 0, 0, 0);
      end
    end
    repeat (4) step(1, 0, 1, 1);
    vectors++;
    if (o_State !== 3'd5 || o_Lives !== 2'd0 || o_Game_Over !== 1'b1 || o_Obstacles_Run !== 1'b0) begin
      miscompares++; $display("FAIL game_over: got state %0d lives %0d go %0b obst %0b expected 5 0 1 0",
                              o_State, o_Lives, o_Game_Over, o_Obstacles_Run);
    end
    step(0, 0, 0, 0);
    step(0, 1, 0, 0);
    vectors++;
    if (o_State !== 3'd1 || o_Lives !== 2'd3 || o_Level !== 3'd0 || o_Frog_Reset !== 1'b1) begin
      miscompares++; $display("FAIL restart: got state %0d lives %0d level %0d fr %0b expected 1 3 0 1",
                              o_State, o_Lives, o_Level, o_Frog_Reset);
    end
    step(0, 0, 0, 0);
    repeat (START_FR) step(1, 0, 0, 0);
  endtask

  task automatic test_level_saturation();
    for (int n = 1; n <= 8; n++) begin
      int exp_lvl;
      exp_lvl = (n > MAX_LVL) ? MAX_LVL : n;
      step(0, 0, 0, 1);
      vectors++;
      if (o_Level !== 3'(exp_lvl) || o_State !== 3'd4) begin
        miscompares++; $display("FAIL level_up %0d: got level %0d state %0d expected %0d 4", n, o_Level, o_State, exp_lvl);
      end
      for (int j = 1; j <= LVL_FR; j++) begin
        step(1, 0, 0, 0);
        if (j < LVL_FR) begin
          vectors++;
          if (o_Obstacles_Run !== 1'b0 || o_State !== 3'd4) begin
            miscompares++; $display("FAIL pause_frozen lvl %0d tick %0d: got obst %0b state %0d expected 0 4",
                                    n, j, o_Obstacles_Run, o_State);
          end
        end
      end
      vectors++;
      if (o_Frog_Reset !== 1'b1 || o_State !== 3'd2) begin
        miscompares++; $display("FAIL pause_exit %0d: got fr %0b state %0d expected 1 2", n, o_Frog_Reset, o_State);
      end
    end
  endtask

  task automatic test_simultaneous();
    do_reset();
    start_game();
    repeat (2) begin
      step(0, 0, 0, 1);
      repeat (LVL_FR) step(1, 0, 0, 0);
    end
    step(0, 0, 1, 1);
    vectors++;
    if (o_Level !== 3'd2 || o_Lives !== 2'd2 || o_State !== 3'd3) begin
      miscompares++; $display("FAIL collide_and_levelup: got level %0d lives %0d state %0d expected 2 2 3",
                              o_Level, o_Lives, o_State);
    end
  endtask

  task automatic test_random();
    logic [12:0] exp;
    do_reset();
    for (int cyc = 0; cyc < 5000; cyc++) begin
      if ($urandom_range(0, 1499) == 0) begin
        do_reset();
      end else begin
        step(1'($urandom_range(0, 1)), $urandom_range(0, 3) == 0,
             $urandom_range(0, 39) == 0, $urandom_range(0, 29) == 0);
      end
      exp = model_vec();
      vectors++;
      if (dut_vec !== exp) begin
        miscompares++; $display("FAIL random cycle %0d: got %b expected %b", cyc, dut_vec, exp);
      end
    end
  endtask

  initial begin
    test_reset();
    test_collision();
    test_reset_mid_hit();
    test_game_over();
    test_level_saturation();
    test_simultaneous();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/game_flow_controller.md
# game_flow_controller

Top-level sequencer for the Frogger game: owns the game state machine, lives counter, level counter and frame-based pause timers. It consumes the debounced start condition (all four switches), the collision flag and the frog level-up pulse. It drives the enables for character control and obstacle movement, a frog-respawn pulse, and the lives/level values for display and difficulty scaling. Timing is paced by the VGA frame tick, so pauses are expressed in frames.

## Interface

- c_LIVES_INI, 3: lives at game start, 1..3
- c_START_FRAMES, 30: countdown length in frames, 1..255
- c_HIT_FRAMES, 60: post-collision freeze length in frames, 1..255
- c_LEVELUP_FRAMES, 90: level-transition pause in frames, 1..255
- c_MAX_LEVEL, 7: level saturation value, 1..7

Ports:

- i_Clk  in  1  system clock; the single clock for the block
- i_Rst_L  in  1  reset, asynchronous assert, active-low
- i_Frame_Tick  in  1  one-cycle pulse per VGA frame
- i_Start  in  1  level-sensitive; all four debounced switches pressed
- i_Has_Collided  in  1  frog/car overlap, level-sensitive
- i_Level_Up  in  1  one-cycle pulse when the frog reaches the top row
- o_Game_Active  out  1  frog movement enable
- o_Obstacles_Run  out  1  car movement enable
- o_Frog_Reset  out  1  one-cycle pulse; frog returns to base position
- o_Blank_Frog  out  1  frog sprite suppress (hit flash)
- o_Lives  out  2  remaining lives
- o_Level  out  3  current level, 0-based
- o_Game_Over  out  1  high in GAME_OVER
- o_State  out  3  state encoding, for debug

## Operation

- States and encodings: IDLE=0, COUNTDOWN=1, RUNNING=2, HIT=3, LEVEL_PAUSE=4, GAME_OVER=5. Codes 6 and 7 go to IDLE on the next clock.
- Start edge: registered previous i_Start; start_edge = i_Start & ~prev. prev resets to 1, so a held switch at reset never starts a game.
- Frame counter (8 bit): cleared on every state entry; increments on i_Frame_Tick. A timed state exits on the tick where count == PARAM-1, which is the PARAM-th tick.
- IDLE or GAME_OVER with start_edge: lives=c_LIVES_INI, level=0, pulse o_Frog_Reset, go to COUNTDOWN.
- COUNTDOWN: exits after c_START_FRAMES to RUNNING. Collisions are ignored.
- RUNNING with i_Has_Collided and lives>1: lives-1, go to HIT.
- RUNNING with i_Has_Collided and lives==1: lives=0, go to GAME_OVER.
- RUNNING with i_Level_Up and no collision: level+1, saturating at c_MAX_LEVEL; go to LEVEL_PAUSE.
- Simultaneous collision and level-up in the same cycle: collision wins; the level is unchanged.
- HIT: exits after c_HIT_FRAMES; pulse o_Frog_Reset; go to RUNNING. Collision and level-up are ignored.
- LEVEL_PAUSE: exits after c_LEVELUP_FRAMES; pulse o_Frog_Reset; go to RUNNING.
- o_Game_Active = (state==RUNNING).
- o_Obstacles_Run = state in {COUNTDOWN, RUNNING, HIT}. Cars are frozen in IDLE, LEVEL_PAUSE and GAME_OVER.
- o_Game_Over = (state==GAME_OVER). Lives and level hold their values there for display.

## Timing

- All outputs are registered. A state change is visible one clock after the cycle in which the trigger is sampled.
- o_Frog_Reset is high for exactly the first clock of the new state.
- Reset values: state IDLE; o_Lives = c_LIVES_INI; o_Level = 0; frame counter 0; every 1-bit output 0.
- Reset asserted mid-game: all registers return to reset values immediately, with no completion of the current timer.
- i_Frame_Tick during a state's entry clock counts toward that state's timer. A tick is never counted twice.
- Lives never underflow. Level never exceeds c_MAX_LEVEL.

## Configuration

- GAME_FLOW_HIT_FLASH_EN defined: in HIT, o_Blank_Frog = frame counter bit 3, toggling every 8 frames. It is 0 in all other states.
- Not defined: o_Blank_Frog is constant 0. HIT duration and all other behaviour are identical.

## Test plan

- Reset with i_Start held high, then 5 frames: stays IDLE, o_Lives=3. Release and press again: o_Frog_Reset pulses once, state=1, and RUNNING (2) is reached exactly on the 30th tick.
- RUNNING, collision: state=3, o_Lives=2, o_Game_Active=0, o_Obstacles_Run=1. After 60 ticks: one o_Frog_Reset pulse, state=2.
- Three collisions from a fresh game: third gives state=5, o_Lives=0, o_Game_Over=1. A start edge then gives o_Lives=3, o_Level=0, state=1.
- Eight i_Level_Up pulses, each followed by a 90-tick pause: o_Level saturates at 7; o_Obstacles_Run=0 during every pause.
- i_Level_Up and i_Has_Collided in the same cycle with o_Level=2, o_Lives=3: o_Level=2, o_Lives=2, state=3.
- With GAME_FLOW_HIT_FLASH_EN: o_Blank_Frog toggles every 8 ticks in HIT. Without it: o_Blank_Frog stays 0. i_Rst_L low mid-HIT gives state 0 on the same edge.
